// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the round-robin / fixed-priority RAM arbiter.
package ram_arb_pkg;

   localparam int ARB_RR    = 0;
   localparam int ARB_FIXED = 1;

   typedef enum logic {
      ST_CLEAR,
      ST_RUN
   } state_t;

   function automatic int clog2_min1(input int n);
      int w;
      w = $clog2(n);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/ram_arb_picker.sv
// Combinational winner selection: rotating search after LAST, or lowest index.
module ram_arb_picker
   import ram_arb_pkg::*;
#(
   parameter int NUM_CLIENTS = 4,
   parameter int ARB_MODE    = ARB_RR,
   parameter int ID_W        = clog2_min1(NUM_CLIENTS)
) (
   input  logic [NUM_CLIENTS-1:0] req,
   input  logic [ID_W-1:0]        last,
   output logic                   valid,
   output logic [ID_W-1:0]        win
);

   int   idx;
   logic found;

   always_comb begin
      valid = |req;
      win   = '0;
      found = 1'b0;
      idx   = 0;
      for (int k = 0; k < NUM_CLIENTS; k++) begin
         if (ARB_MODE == ARB_FIXED)
            idx = k;
         else
            idx = (int'(last) + 1 + k) % NUM_CLIENTS;
         if (!found && req[idx]) begin
            found = 1'b1;
            win   = ID_W'(idx);
         end
      end
   end

endmodule

// File: rtl/ram_arbiter_rr.sv
// N-client single-port RAM arbiter; clears the RAM after reset, then serves
// one read or write per clock to the picked client.
module ram_arbiter_rr
   import ram_arb_pkg::*;
#(
   parameter int NUM_CLIENTS = 4,
   parameter int DATA_W      = 8,
   parameter int ADDR_W      = 4,
   parameter int ARB_MODE    = ARB_RR,
   localparam int ID_W       = clog2_min1(NUM_CLIENTS)
) (
   input  logic                          CLOCK,
   input  logic                          RST_N,
   output logic                          RST_DONE,
   input  logic [NUM_CLIENTS-1:0]        REQ,
   input  logic [NUM_CLIENTS-1:0]        RD_NOT_WR,
   input  logic [NUM_CLIENTS*ADDR_W-1:0] ADDR,
   input  logic [NUM_CLIENTS*DATA_W-1:0] WDATA,
   output logic [NUM_CLIENTS-1:0]        ACK,
   output logic [ID_W-1:0]               GNT_ID,
   output logic [DATA_W-1:0]             RDATA
);

   localparam int DEPTH = 1 << ADDR_W;
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

   logic [DATA_W-1:0] mem [DEPTH];

   state_t            state, state_nxt;
   logic [ADDR_W-1:0] clr_cnt;
   logic [ID_W-1:0]   last;
   logic              pick_valid;
   logic [ID_W-1:0]   win;

   logic                   grant;
   logic                   rd_en;
   logic                   mem_we;
   logic [ADDR_W-1:0]      mem_addr;
   logic [DATA_W-1:0]      mem_wdata;
   logic [NUM_CLIENTS-1:0] onehot;
   logic                   clr_done;

   ram_arb_picker #(
      .NUM_CLIENTS (NUM_CLIENTS),
      .ARB_MODE    (ARB_MODE),
      .ID_W        (ID_W)
   ) u_picker (
      .req   (REQ),
      .last  (last),
      .valid (pick_valid),
      .win   (win)
   );

   assign clr_done = (state == ST_CLEAR) && (clr_cnt == LAST_ADDR);

   always_ff @(posedge CLOCK or negedge RST_N) begin
      if (!RST_N) state <= ST_CLEAR;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         ST_CLEAR: if (clr_done) state_nxt = ST_RUN;
         ST_RUN:   state_nxt = ST_RUN;
      endcase
   end

   always_comb begin
      grant     = 1'b0;
      rd_en     = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      onehot    = '0;
      unique case (state)
         ST_CLEAR: begin
            mem_we   = 1'b1;
            mem_addr = clr_cnt;
         end
         ST_RUN: if (pick_valid) begin
            grant       = 1'b1;
            onehot[win] = 1'b1;
            mem_addr    = ADDR[int'(win)*ADDR_W +: ADDR_W];
            if (RD_NOT_WR[win]) begin
               rd_en = 1'b1;
            end else begin
               mem_we    = 1'b1;
               mem_wdata = WDATA[int'(win)*DATA_W +: DATA_W];
            end
         end
      endcase
   end

   // The array itself is not reset; the clear sequence zeroes it instead.
   always_ff @(posedge CLOCK) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
   end

   always_ff @(posedge CLOCK or negedge RST_N) begin
      if (!RST_N) begin
         clr_cnt  <= '0;
         RST_DONE <= 1'b0;
         last     <= ID_W'(NUM_CLIENTS - 1);
         ACK      <= '0;
         GNT_ID   <= '0;
         RDATA    <= '0;
      end else begin
         if (state == ST_CLEAR) clr_cnt <= clr_cnt + 1'b1;
         if (clr_done) RST_DONE <= 1'b1;
         ACK <= onehot;
         if (grant) begin
            GNT_ID <= win;
            if (ARB_MODE == ARB_RR) last <= win;
         end
         if (rd_en) RDATA <= mem[mem_addr];
      end
   end

endmodule

// File: tb/tb_ram_arbiter_rr.sv
// Directed bench: a round-robin and a fixed-priority instance share clock/reset.
module tb_ram_arbiter_rr;

   logic        clk;
   logic        rst_n;
   logic [3:0]  req, rnw, ack;
   logic [15:0] addr;
   logic [31:0] wdata;
   logic [1:0]  gnt;
   logic [7:0]  rdata;
   logic        rst_done;

   logic [3:0]  req_f, ack_f;
   logic [1:0]  gnt_f;
   logic [7:0]  rdata_f;
   logic        rst_done_f;

   int checks = 0;
   int failures = 0;

   ram_arbiter_rr #(
      .NUM_CLIENTS (4), .DATA_W (8), .ADDR_W (4), .ARB_MODE (0)
   ) dut (
      .CLOCK (clk), .RST_N (rst_n), .RST_DONE (rst_done),
      .REQ (req), .RD_NOT_WR (rnw), .ADDR (addr), .WDATA (wdata),
      .ACK (ack), .GNT_ID (gnt), .RDATA (rdata)
   );

   ram_arbiter_rr #(
      .NUM_CLIENTS (4), .DATA_W (8), .ADDR_W (4), .ARB_MODE (1)
   ) dut_f (
      .CLOCK (clk), .RST_N (rst_n), .RST_DONE (rst_done_f),
      .REQ (req_f), .RD_NOT_WR (4'b1111), .ADDR (16'h0000),
      .WDATA (32'h0),
      .ACK (ack_f), .GNT_ID (gnt_f), .RDATA (rdata_f)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_client(input int c, input logic rd,
                             input logic [3:0] a, input logic [7:0] d);
      rnw[c]           = rd;
      addr[c*4 +: 4]   = a;
      wdata[c*8 +: 8]  = d;
   endtask

   task automatic do_reset();
      req   = '0;
      req_f = '0;
      rst_n = 1'b0;
      #2;
      rst_n = 1'b1;
      repeat (16) tick();
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      req   = 4'b0001;
      set_client(0, 1'b1, 4'h0, 8'h00);
      #12;
      checks++;
      if (rst_done !== 1'b0 || ack !== 4'b0 || gnt !== 2'd0 ||
          rdata !== 8'h00) begin
         failures++;
         $display("FAIL reset_values done=%b ack=%b gnt=%0d rdata=%h expected 0",
                  rst_done, ack, gnt, rdata);
      end
      rst_n = 1'b1;
      for (int e = 1; e <= 16; e++) begin
         tick();
         checks++;
         if (ack !== 4'b0 || rst_done !== (e == 16)) begin
            failures++;
            $display("FAIL clear_edge%0d ack=%b done=%b expected ack=0000 done=%b",
                     e, ack, rst_done, (e == 16));
         end
      end
      for (int i = 0; i < 16; i++) begin
         set_client(0, 1'b1, 4'(i), 8'h00);
         tick();
         checks++;
         if (ack !== 4'b0001 || gnt !== 2'd0 || rdata !== 8'h00) begin
            failures++;
            $display("FAIL clear_read%0d ack=%b gnt=%0d rdata=%h expected 0001/0/00",
                     i, ack, gnt, rdata);
         end
      end
      req = '0;
   endtask

   task automatic test_write_read();
      do_reset();
      set_client(2, 1'b0, 4'hA, 8'hA5);
      req = 4'b0100;
      tick();
      checks++;
      if (ack !== 4'b0100 || gnt !== 2'd2) begin
         failures++;
         $display("FAIL wr_ack ack=%b gnt=%0d expected 0100/2", ack, gnt);
      end
      set_client(2, 1'b1, 4'hA, 8'h00);
      tick();
      checks++;
      if (ack !== 4'b0100 || gnt !== 2'd2 || rdata !== 8'hA5) begin
         failures++;
         $display("FAIL rd_back ack=%b gnt=%0d rdata=%h expected 0100/2/a5",
                  ack, gnt, rdata);
      end
      req = '0;
      tick();
      checks++;
      if (ack !== 4'b0 || gnt !== 2'd2 || rdata !== 8'hA5) begin
         failures++;
         $display("FAIL idle_hold ack=%b gnt=%0d rdata=%h expected 0000/2/a5",
                  ack, gnt, rdata);
      end
   endtask

   task automatic test_round_robin();
      logic [1:0] exp_a [8];
      logic [1:0] exp_b [4];
      exp_a = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3};
      exp_b = '{2'd1, 2'd3, 2'd1, 2'd3};
      do_reset();
      for (int c = 0; c < 4; c++) set_client(c, 1'b1, 4'h0, 8'h00);
      req = 4'b1111;
      for (int i = 0; i < 8; i++) begin
         tick();
         checks++;
         if (gnt !== exp_a[i] || ack !== (4'b0001 << exp_a[i])) begin
            failures++;
            $display("FAIL rr_all%0d gnt=%0d ack=%b expected %0d", i, gnt, ack,
                     exp_a[i]);
         end
      end
      req = 4'b1010;
      for (int i = 0; i < 4; i++) begin
         tick();
         checks++;
         if (gnt !== exp_b[i] || ack !== (4'b0001 << exp_b[i])) begin
            failures++;
            $display("FAIL rr_1010_%0d gnt=%0d ack=%b expected %0d", i, gnt, ack,
                     exp_b[i]);
         end
      end
      req = '0;
   endtask

   task automatic test_fixed_priority();
      do_reset();
      req_f = 4'b1110;
      for (int i = 0; i < 4; i++) begin
         tick();
         checks++;
         if (ack_f !== 4'b0010 || gnt_f !== 2'd1) begin
            failures++;
            $display("FAIL fixed_c1_%0d ack=%b gnt=%0d expected 0010/1", i, ack_f,
                     gnt_f);
         end
      end
      req_f = 4'b1100;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if (ack_f !== 4'b0100 || gnt_f !== 2'd2) begin
            failures++;
            $display("FAIL fixed_c2_%0d ack=%b gnt=%0d expected 0100/2", i, ack_f,
                     gnt_f);
         end
      end
      req_f = '0;
   endtask

   task automatic test_cross_client();
      do_reset();
      set_client(0, 1'b0, 4'h9, 8'h3C);
      set_client(3, 1'b1, 4'h9, 8'h00);
      req = 4'b1001;
      tick();
      checks++;
      if (ack !== 4'b0001 || gnt !== 2'd0) begin
         failures++;
         $display("FAIL cross_wr ack=%b gnt=%0d expected 0001/0", ack, gnt);
      end
      req = 4'b1000;
      tick();
      checks++;
      if (ack !== 4'b1000 || gnt !== 2'd3 || rdata !== 8'h3C) begin
         failures++;
         $display("FAIL cross_rd ack=%b gnt=%0d rdata=%h expected 1000/3/3c",
                  ack, gnt, rdata);
      end
      req = '0;
   endtask

   task automatic test_back_to_back_reset();
      do_reset();
      set_client(1, 1'b0, 4'h5, 8'h77);
      req = 4'b0010;
      tick();
      checks++;
      if (ack !== 4'b0010) begin
         failures++;
         $display("FAIL mid_wr ack=%b expected 0010", ack);
      end
      for (int c = 0; c < 4; c++) set_client(c, 1'b1, 4'h5, 8'h00);
      req = 4'b1111;
      repeat (3) tick();
      checks++;
      if (rdata !== 8'h77 || ack === 4'b0) begin
         failures++;
         $display("FAIL mid_stream rdata=%h ack=%b expected 77 nonzero", rdata, ack);
      end
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (ack !== 4'b0 || gnt !== 2'd0 || rdata !== 8'h00 || rst_done !== 1'b0) begin
         failures++;
         $display("FAIL mid_reset ack=%b gnt=%0d rdata=%h done=%b expected 0",
                  ack, gnt, rdata, rst_done);
      end
      #1;
      rst_n = 1'b1;
      for (int e = 1; e <= 16; e++) begin
         tick();
         checks++;
         if (ack !== 4'b0 || rst_done !== (e == 16)) begin
            failures++;
            $display("FAIL reclear_edge%0d ack=%b done=%b expected ack=0000 done=%b",
                     e, ack, rst_done, (e == 16));
         end
      end
      req = 4'b0010;
      tick();
      checks++;
      if (ack !== 4'b0010 || gnt !== 2'd1 || rdata !== 8'h00) begin
         failures++;
         $display("FAIL reclear_read ack=%b gnt=%0d rdata=%h expected 0010/1/00",
                  ack, gnt, rdata);
      end
      req = '0;
   endtask

   initial begin
      clk   = 1'b0;
      rst_n = 1'b0;
      req   = '0;
      req_f = '0;
      rnw   = '1;
      addr  = '0;
      wdata = '0;
      test_reset();
      test_write_read();
      test_round_robin();
      test_fixed_priority();
      test_cross_client();
      test_back_to_back_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
